// File: rtl/sdf_stage_ctrl.sv
// Control sequencer for one radix-2 SDF FFT stage: delay-line step, butterfly select, twiddle address, output framing.
// Outputs decode combinationally from registered state plus in_valid; in_ready drops only while flushing zeros.
module sdf_stage_ctrl #(
    parameter int MEMORY_DEPTH  = 8,
    parameter int CNT_WIDTH     = 4,
    parameter int TW_ADDR_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic                     flush,
    output logic                     in_ready,
    output logic                     step,
    output logic                     zero_in,
    output logic                     bf_sel,
    output logic [TW_ADDR_WIDTH-1:0] tw_addr,
    output logic                     out_valid,
    output logic                     out_sof,
    output logic                     busy,
    output logic                     sof_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_HALF  = CNT_WIDTH'(MEMORY_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LASTH = CNT_WIDTH'(MEMORY_DEPTH - 1);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   sof_err_q, sof_err_d;
    logic                   resync;

    always_comb begin
        // A start-of-frame mid-count realigns the stage onto the new frame.
        resync    = in_valid & in_sof & (cnt_q != '0) & ((state_q == S_FILL) | (state_q == S_RUN));
        bf_sel    = cnt_q[CNT_WIDTH-1];
        tw_addr   = bf_sel ? '0 : cnt_q[TW_ADDR_WIDTH-1:0];
        zero_in   = (state_q == S_FLUSH);
        in_ready  = (state_q != S_FLUSH);
        busy      = (state_q != S_IDLE);
        sof_err   = sof_err_q;

        step = 1'b0;
        unique case (state_q)
            S_IDLE:         step = in_valid & in_sof;
            S_FILL, S_RUN:  step = in_valid;
            S_FLUSH:        step = 1'b1;
            default:        step = 1'b0;
        endcase

        out_valid = step & ((state_q == S_RUN) | (state_q == S_FLUSH)) & ~resync;
        out_sof   = out_valid & (state_q == S_RUN) & (cnt_q == CNT_HALF);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sof_err_d = sof_err_q | resync;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid & in_sof) begin
                    state_d = S_FILL;
                    cnt_d   = CNT_ONE;
                end
            end
            S_FILL, S_RUN: begin
                if (resync) begin
                    state_d = S_FILL;
                    cnt_d   = CNT_ONE;
                end else if (in_valid) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if ((state_q == S_FILL) && (cnt_q == CNT_LASTH)) begin
                        state_d = S_RUN;
                    end
                end else if ((state_q == S_RUN) && flush && (cnt_q == '0)) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (cnt_q == CNT_LASTH) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sof_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sof_err_q <= sof_err_d;
        end
    end

endmodule
